// File: rtl/vram_pkg.sv
// Shared types and default sizing for the video RAM arbiter.
package vram_pkg;

  localparam int DEF_ADDR_W     = 13;
  localparam int DEF_DATA_W     = 3;
  localparam int DEF_FIFO_DEPTH = 4;

  // Who owns the RAM port in a given cycle.
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_VGA  = 2'd1,
    GNT_CPU  = 2'd2
  } grant_t;

  // One buffered CPU pixel write, packed as {addr, data}.
  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } wrEntry_t;

endpackage

// File: rtl/vram_wr_fifo.sv
// Small synchronous FIFO buffering CPU pixel writes until the RAM is idle.
module vram_wr_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   iPush,
  input  logic [W-1:0]           iPushData,
  input  logic                   iPop,
  output logic [W-1:0]           oHead,
  output logic                   oFull,
  output logic                   oEmpty,
  output logic [$clog2(DEPTH):0] oCount
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             doPush;
  logic             doPop;

  assign oFull  = (oCount == ($clog2(DEPTH) + 1)'(DEPTH));
  assign oEmpty = (oCount == '0);
  assign doPush = iPush && !oFull;
  assign doPop  = iPop && !oEmpty;
  assign oHead  = mem[rdPtr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wrPtr  <= '0;
      rdPtr  <= '0;
      oCount <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   oCount <= oCount + 1'b1;
        2'b01:   oCount <= oCount - 1'b1;
        default: oCount <= oCount;
      endcase
    end
  end

  // Entry storage; contents are meaningless while the slot is not occupied.
  always_ff @(posedge Clock) begin
    if (doPush) mem[wrPtr] <= iPushData;
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: VGA reads win, CPU writes are buffered and drained on idle cycles.
module vram_arbiter import vram_pkg::*; #(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              iVgaReq,
  input  logic [ADDR_W-1:0] iVgaAddr,
  output logic              oVgaValid,
  output logic [DATA_W-1:0] oVgaData,
  input  logic              iCpuWrEn,
  input  logic [ADDR_W-1:0] iCpuAddr,
  input  logic [DATA_W-1:0] iCpuData,
  output logic              oCpuReady,
  output logic              oWrOverflow,
  output logic [ADDR_W-1:0] oRamAddr,
  output logic              oRamWrEn,
  output logic [DATA_W-1:0] oRamWrData,
  input  logic [DATA_W-1:0] iRamRdData
);

  localparam int ENTRY_W = ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

  grant_t             grant;
  logic               push;
  logic               pop;
  logic               fifoFull;
  logic               fifoEmpty;
  logic [CNT_W-1:0]   fifoCount;
  logic [ENTRY_W-1:0] head;
  logic               vgaVld_p0;
  logic               vgaVld_p1;

  // Readiness ignores a same-cycle pop so it depends only on registered state.
  assign oCpuReady = (fifoCount < CNT_W'(FIFO_DEPTH));
  assign push      = iCpuWrEn && oCpuReady;
  assign pop       = (grant == GNT_CPU);

  vram_wr_fifo #(
    .W     (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) uFifo (
    .Clock     (Clock),
    .Reset     (Reset),
    .iPush     (push),
    .iPushData ({iCpuAddr, iCpuData}),
    .iPop      (pop),
    .oHead     (head),
    .oFull     (fifoFull),
    .oEmpty    (fifoEmpty),
    .oCount    (fifoCount)
  );

  // Fixed priority: VGA first, then any pending CPU write.
  always_comb begin
    grant = GNT_NONE;
    if (iVgaReq)         grant = GNT_VGA;
    else if (!fifoEmpty) grant = GNT_CPU;
  end

  // Stage 0: registered RAM command for the granted requester.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      oRamAddr   <= '0;
      oRamWrEn   <= 1'b0;
      oRamWrData <= '0;
    end else begin
      case (grant)
        GNT_VGA: begin
          oRamAddr <= iVgaAddr;
          oRamWrEn <= 1'b0;
        end
        GNT_CPU: begin
          oRamAddr   <= head[ENTRY_W-1:DATA_W];
          oRamWrData <= head[DATA_W-1:0];
          oRamWrEn   <= 1'b1;
        end
        default: oRamWrEn <= 1'b0;
      endcase
    end
  end

  // Stages 1-2: read-valid shift register; RAM data is captured as it leaves stage 1.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      vgaVld_p0 <= 1'b0;
      vgaVld_p1 <= 1'b0;
      oVgaValid <= 1'b0;
      oVgaData  <= '0;
    end else begin
      vgaVld_p0 <= (grant == GNT_VGA);
      vgaVld_p1 <= vgaVld_p0;
      oVgaValid <= vgaVld_p1;
      if (vgaVld_p1) oVgaData <= iRamRdData;
    end
  end

  // Sticky record of any write that found the FIFO full.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)                     oWrOverflow <= 1'b0;
    else if (iCpuWrEn && fifoFull)  oWrOverflow <= 1'b1;
  end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Arbiter for the single-port video RAM that sits between the MiniAlu core and the VGA scan-out logic. It shares the RAM between two requesters: VGA pixel reads, which have strict priority, and CPU pixel writes, which are buffered in a small FIFO and drained on idle RAM cycles. The RAM command outputs and the VGA read-data output are registered, so the VGA read latency is fixed. The block sits inside MiniAlu between the instruction datapath and the VGA_RED/GREEN/BLUE pixel path.

## Interface
Parameters:
- ADDR_W, 13, RAM word address width (80x60 framebuffer uses 4800 words).
- DATA_W, 3, pixel width ({R,G,B}).
- FIFO_DEPTH, 4, CPU write FIFO entries; must be a power of 2, at least 2.

Ports:
- Clock  in  1  system clock; all state is on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- iVgaReq  in  1  VGA pixel read request, sampled each edge.
- iVgaAddr  in  ADDR_W  read address, qualified by iVgaReq.
- oVgaValid  out  1  one-cycle pulse: oVgaData holds the requested pixel.
- oVgaData  out  DATA_W  read data; holds its value between pulses.
- iCpuWrEn  in  1  CPU write strobe, one write per asserted cycle.
- iCpuAddr  in  ADDR_W  write address.
- iCpuData  in  DATA_W  write data.
- oCpuReady  out  1  FIFO can accept a write this cycle.
- oWrOverflow  out  1  sticky flag: a write arrived while oCpuReady was 0.
- oRamAddr  out  ADDR_W  registered RAM address.
- oRamWrEn  out  1  registered RAM write enable.
- oRamWrData  out  DATA_W  registered RAM write data.
- iRamRdData  in  DATA_W  RAM read data, valid one cycle after the address is presented.

## Operation
- The grant is decided every cycle and encoded as GNT_NONE, GNT_VGA or GNT_CPU.
  - iVgaReq=1 gives GNT_VGA.
  - Otherwise, a non-empty FIFO gives GNT_CPU.
  - Otherwise, GNT_NONE.
- GNT_VGA:
  - oRamAddr<=iVgaAddr and oRamWrEn<=0.
  - A 2-stage valid shift register tracks the read; its output loads oVgaData<=iRamRdData and pulses oVgaValid.
- GNT_CPU: the FIFO head is popped; oRamAddr<=head.addr, oRamWrData<=head.data, oRamWrEn<=1.
- GNT_NONE: oRamWrEn<=0; oRamAddr and oRamWrData keep their values.
- Usage contract: VGA requests arrive at most every other cycle (pixel clock = Clock/2). This guarantees the FIFO drains at least one entry per 2 cycles. The arbiter does not enforce the contract.
- FIFO push happens when iCpuWrEn && oCpuReady.
  - oCpuReady = (count < FIFO_DEPTH). It does not anticipate a pop in the same cycle.
  - A write while full is dropped and sets oWrOverflow. oWrOverflow clears only on reset.
- Push and pop in the same cycle are both performed; count is unchanged.
- No forwarding: a VGA read of an address with a pending FIFO write returns the old RAM contents.
- Writes are committed in FIFO order. The FIFO pointers wrap modulo FIFO_DEPTH.

## Timing
- VGA read latency:
  - iVgaReq sampled at edge E0.
  - oRamAddr is valid after E0.
  - iRamRdData is valid after E1.
  - oVgaValid=1 and oVgaData are updated after E2, for exactly one cycle.
  - Latency is fixed at 3 edges and is not affected by CPU traffic.
- CPU write: accepted at edge E0. With no VGA contention it is popped at E1, and oRamWrEn=1 in the cycle after E1.
- Reset asserted (asynchronous):
  - oVgaValid=0, oVgaData=0.
  - oRamAddr=0, oRamWrEn=0, oRamWrData=0.
  - oWrOverflow=0, oCpuReady=1.
  - FIFO emptied and valid pipeline cleared.
- Reset asserted mid-read: the in-flight oVgaValid pulse is discarded and not re-issued.
- Reset deasserts synchronously into the logic; the first grant is decided at the first edge after deassertion.

## Structure
- Package vram_pkg holds:
  - grant encoding typedef (GNT_NONE/GNT_VGA/GNT_CPU);
  - default ADDR_W/DATA_W/FIFO_DEPTH constants;
  - the FIFO entry struct {addr, data}.
- One sub-module, vram_wr_fifo: a synchronous FIFO with push/pop/full/empty/count and the same asynchronous active-low reset.
- Arbitration, RAM command registers and the read-valid pipeline live in vram_arbiter.

## Test plan
- Single read: iVgaReq=1 with iVgaAddr=0x012 for one cycle, RAM model holding 3'b101 at 0x012 -> oVgaValid pulses once exactly 3 edges later, oVgaData=3'b101.
- Write drain: 3 CPU writes (0x100/1, 0x101/2, 0x102/3) on consecutive cycles, no VGA traffic -> oRamWrEn high for 3 consecutive cycles, in order, starting 1 edge after the first write.
- Contention: iVgaReq toggling 1,0,1,0 while 4 writes are queued -> every VGA read still returns at latency 3; the writes occupy only the non-VGA cycles and all 4 commit within 8 cycles.
- Full/overflow, FIFO_DEPTH=4, VGA requesting every cycle:
  - 5 writes -> oCpuReady=0 after the 4th write.
  - The 5th write is dropped and oWrOverflow=1.
  - After VGA stops, exactly 4 RAM writes occur.
- Hazard: write 0x020=3'b111 queued behind VGA traffic, then a VGA read of 0x020 that holds 3'b000 -> the read returns 3'b000; a read after the drain returns 3'b111.
- Reset mid-operation: pull Reset low 1 cycle after a VGA request with 2 writes queued -> no oVgaValid pulse; all outputs take their reset values and oCpuReady=1; no RAM write after release.
